// File: rtl/apb_mem_stub.sv
// ---------------------------------------------------------------------------
// apb_mem_stub
//   APB4 completer model: a word-addressed memory of DEPTH words with byte
//   strobes, fixed or pseudo-random wait states, and an error response for
//   accesses beyond the populated address range.
//
// Ports
//   pclk     in   clock
//   preset   in   synchronous reset, active-high
//   psel     in   completer select
//   penable  in   access phase
//   pprot    in   protection attributes (accepted, never cause an error)
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address; the low DSIZE bits are ignored
//   pstrb    in   write byte strobes
//   pwdata   in   write data
//   prdata   out  read data, nonzero only while pready=1 on an error-free read
//   pready   out  transfer complete
//   pslverr  out  error response, only asserted together with pready
// ---------------------------------------------------------------------------
module apb_mem_stub #(
    parameter int         AWIDTH    = 10,
    parameter int         DSIZE     = 2,
    parameter int         DEPTH     = 64,
    parameter int         WAITS     = 0,
    parameter int         WAIT_MODE = 0,
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic                        psel,
    input  logic                        penable,
    input  logic [2:0]                  pprot,
    input  logic                        pwrite,
    input  logic [AWIDTH-1:0]           paddr,
    input  logic [(1<<DSIZE)-1:0]       pstrb,
    input  logic [(1<<DSIZE)*8-1:0]     pwdata,
    output logic [(1<<DSIZE)*8-1:0]     prdata,
    output logic                        pready,
    output logic                        pslverr
);

    localparam int DBYTES = 1 << DSIZE;
    localparam int DWIDTH = DBYTES * 8;
    localparam int IDXW   = $clog2(DEPTH);
    // One extra bit so a fully populated address space never flags an error.
    localparam logic [AWIDTH:0] LIMIT = (AWIDTH+1)'(DEPTH * DBYTES);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        lfsr_q, lfsr_d;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] wr_word;
    logic              complete;
    logic              setup;
    logic [7:0]        lfsr_mod;
    logic              lfsr_fb;
    logic              unused_bits;

    // Protection attributes and the upper bits of the modulo result carry no
    // meaning for this model.
    assign unused_bits = ^{pprot, lfsr_mod[7:4]};

    // x^8+x^6+x^5+x^4+1, Fibonacci form shifting towards the MSB.
    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_mod = lfsr_q % 8'(WAITS + 1);

    assign setup    = psel && !penable;
    assign pready   = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign complete = pready && psel && penable;
    assign pslverr  = err_q && pready;
    assign prdata   = (pready && !pwrite && !err_q) ? mem_q[idx_q] : '0;

    // Byte-merged word written back on an error-free write completion.
    genvar gi;
    generate
        for (gi = 0; gi < DBYTES; gi++) begin : g_merge
            assign wr_word[gi*8 +: 8] = pstrb[gi] ? pwdata[gi*8 +: 8]
                                                  : mem_q[idx_q][gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            ST_IDLE: begin
                // penable without a preceding setup phase is ignored here.
                if (setup) begin
                    state_d = ST_ACCESS;
                    idx_d   = paddr[DSIZE +: IDXW];
                    err_d   = ({1'b0, paddr} >= LIMIT);
                    cnt_d   = (WAIT_MODE == 1) ? lfsr_mod[3:0] : 4'(WAITS);
                    lfsr_d  = {lfsr_q[6:0], lfsr_fb};
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    // Requester gave up: abort without touching memory.
                    state_d = ST_IDLE;
                end else if (penable) begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Memory is cleared on reset, so it lives in flops rather than a RAM.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && pwrite && !err_q) begin
            mem_q[idx_q] <= wr_word;
        end
    end

endmodule
